flt2fix_sequencer: RTL

Controller that sequences the half-precision-to-8.8-fixed conversion datapath against the byte-wide data memory. On a start request it fetches each 16-bit float operand as two bytes, runs it through the conversion core, writes the 16-bit fixed result back as two bytes, and acknowledges the test bench with a one-cycle `done` pulse. It supports a batch of `COUNT` operands per request.

---
 rtl/flt2fix_pkg.sv | 42 ++++
 rtl/flt2fix_core.sv | 70 +++++++
 rtl/flt2fix_sequencer.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/flt2fix_pkg.sv
// -----------------------------------------------------------------------------
// flt2fix_pkg
// Shared definitions for the half-precision to 8.8 fixed-point sequencer:
// FSM state encodings, conversion constants and the magnitude bit position.
// No ports (package).
// -----------------------------------------------------------------------------
package flt2fix_pkg;

  // FSM state encodings (plain constants so legacy code can compare raw bits)
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_RD_LO = 3'd1;
  localparam logic [2:0] ST_RD_HI = 3'd2;
  localparam logic [2:0] ST_CAPT  = 3'd3;
  localparam logic [2:0] ST_CONV  = 3'd4;
  localparam logic [2:0] ST_WR_LO = 3'd5;
  localparam logic [2:0] ST_WR_HI = 3'd6;
  localparam logic [2:0] ST_DONE  = 3'd7;

  // Typed view of the same encodings, for debug and newer code
  typedef enum logic [2:0] {
    S_IDLE  = ST_IDLE,
    S_RD_LO = ST_RD_LO,
    S_RD_HI = ST_RD_HI,
    S_CAPT  = ST_CAPT,
    S_CONV  = ST_CONV,
    S_WR_LO = ST_WR_LO,
    S_WR_HI = ST_WR_HI,
    S_DONE  = ST_DONE
  } state_e;

  localparam int EXP_BIAS  = 15;
  localparam int FRAC_BITS = 8;

  // {hidden, m} << e carries 10 mantissa fraction bits plus the exponent
  // bias; dropping (10 + bias - frac) LSBs leaves the 8.8 magnitude.
  localparam int MAG_LSB = 10 + EXP_BIAS - FRAC_BITS;

  localparam logic [4:0]  SAT_EXP = 5'd22;
  localparam logic [15:0] POS_MAX = 16'h7FFF;
  localparam logic [15:0] NEG_MAX = 16'h8000;

endpackage

// File: rtl/flt2fix_core.sv
// -----------------------------------------------------------------------------
// flt2fix_core
// Combinational IEEE half-precision to signed 8.8 fixed-point converter.
// Out-of-range values, inf and NaN saturate to 0x7FFF / 0x8000 by sign.
//
// Build option: define FLT2FIX_ROUND_EN to round the magnitude to nearest
// even before negation; otherwise the magnitude is truncated.
//
// Ports:
//   flt  in  [15:0]  half-precision operand
//   fix  out [15:0]  8.8 two's-complement result
// -----------------------------------------------------------------------------
module flt2fix_core
  import flt2fix_pkg::*;
(
  input  logic [15:0] flt,
  output logic [15:0] fix
);

  logic        sgn;
  logic [4:0]  expo;
  logic [9:0]  mant;
  logic [41:0] f;
  logic [14:0] mag;
  logic [14:0] mag_f;
  logic        sat;
  logic        sat_f;
  logic [15:0] mag_ext;

  assign sgn  = flt[15];
  assign expo = flt[14:10];
  assign mant = flt[9:0];

  // Denormals get a hidden bit of 0, so zero of either sign maps to 0.
  assign f   = {31'b0, (expo != 5'd0), mant} << expo;
  assign mag = f[MAG_LSB+14:MAG_LSB];
  assign sat = (expo >= SAT_EXP) || (f[41:32] != 10'd0);

`ifdef FLT2FIX_ROUND_EN
  logic        lsb_bit;
  logic        guard_bit;
  logic        sticky_bit;
  logic [15:0] mag_r;

  assign lsb_bit    = f[MAG_LSB];
  assign guard_bit  = f[MAG_LSB-1];
  assign sticky_bit = |f[MAG_LSB-2:0];
  assign mag_r      = {1'b0, mag} + {15'd0, guard_bit & (lsb_bit | sticky_bit)};
  // A carry into bit 15 means the rounded value no longer fits 8.8.
  assign mag_f      = mag_r[14:0];
  assign sat_f      = sat | mag_r[15];
`else
  logic unused_round_bits;

  assign unused_round_bits = ^f[MAG_LSB-1:0];
  assign mag_f             = mag;
  assign sat_f             = sat;
`endif

  assign mag_ext = {1'b0, mag_f};

  always_comb begin
    if (sat_f) begin
      fix = sgn ? NEG_MAX : POS_MAX;
    end else begin
      fix = sgn ? (16'd0 - mag_ext) : mag_ext;
    end
  end

endmodule

// File: rtl/flt2fix_sequencer.sv
// -----------------------------------------------------------------------------
// flt2fix_sequencer
// Fetches COUNT half-precision operands (two bytes each) from a byte-wide
// memory, converts each through flt2fix_core, writes the 8.8 results back as
// two bytes and pulses done. Six cycles per element plus one DONE cycle.
// Rounding mode is selected in flt2fix_core by FLT2FIX_ROUND_EN.
//
// Parameters:
//   SRC_BASE  byte address of operand 0 low byte
//   DST_BASE  byte address of result 0 low byte
//   COUNT     operands per request, 1..64
// Ports:
//   clk          in       clock
//   reset        in       synchronous, active-high reset
//   start        in       request; a falling edge seen in IDLE triggers
//   done         out      one-cycle completion pulse
//   busy         out      high in every state except IDLE
//   mem_addr     out [7:0] memory byte address
//   mem_rd_en    out      read strobe, data returns next cycle
//   mem_rd_data  in  [7:0] registered read data
//   mem_wr_en    out      write strobe, committed at the clock edge
//   mem_wr_data  out [7:0] write byte
// -----------------------------------------------------------------------------
module flt2fix_sequencer
  import flt2fix_pkg::*;
#(
  parameter logic [7:0] SRC_BASE = 8'd4,
  parameter logic [7:0] DST_BASE = 8'd6,
  parameter int         COUNT    = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic       done,
  output logic       busy,
  output logic [7:0] mem_addr,
  output logic       mem_rd_en,
  input  logic [7:0] mem_rd_data,
  output logic       mem_wr_en,
  output logic [7:0] mem_wr_data
);

  localparam logic [5:0] LAST_IDX = 6'(COUNT - 1);

  logic [2:0]  state;
  logic        start_q;
  logic [5:0]  idx;
  logic [7:0]  lo_byte;
  logic [7:0]  hi_byte;
  logic [15:0] result;
  logic [15:0] core_fix;
  logic [7:0]  ofs;

  // Byte offset 2*i; the 8-bit address sums below wrap modulo 256.
  assign ofs = {1'b0, idx, 1'b0};

  flt2fix_core u_core (
    .flt ({hi_byte, lo_byte}),
    .fix (core_fix)
  );

  // NOTE: all state is updated with non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the operand/result registers are reset too; they are few and
      // it keeps post-reset simulation free of unknowns.
      state   <= ST_IDLE;
      start_q <= 1'b0;
      idx     <= 6'd0;
      lo_byte <= 8'd0;
      hi_byte <= 8'd0;
      result  <= 16'd0;
    end else begin
      start_q <= start;
      case (state)
        ST_IDLE: begin
          if (start_q && !start) begin
            state <= ST_RD_LO;
            idx   <= 6'd0;
          end
        end
        ST_RD_LO: state <= ST_RD_HI;
        ST_RD_HI: begin
          lo_byte <= mem_rd_data;   // data for the RD_LO address
          state   <= ST_CAPT;
        end
        ST_CAPT: begin
          hi_byte <= mem_rd_data;   // data for the RD_HI address
          state   <= ST_CONV;
        end
        ST_CONV: begin
          result <= core_fix;
          state  <= ST_WR_LO;
        end
        ST_WR_LO: state <= ST_WR_HI;
        ST_WR_HI: begin
          if (idx != LAST_IDX) begin
            idx   <= idx + 6'd1;
            state <= ST_RD_LO;
          end else begin
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          idx   <= 6'd0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    mem_addr    = 8'd0;
    mem_rd_en   = 1'b0;
    mem_wr_en   = 1'b0;
    mem_wr_data = 8'd0;
    case (state)
      ST_RD_LO: begin
        mem_addr  = SRC_BASE + ofs;
        mem_rd_en = 1'b1;
      end
      ST_RD_HI: begin
        mem_addr  = SRC_BASE + ofs + 8'd1;
        mem_rd_en = 1'b1;
      end
      ST_WR_LO: begin
        mem_addr    = DST_BASE + ofs;
        mem_wr_en   = 1'b1;
        mem_wr_data = result[7:0];
      end
      ST_WR_HI: begin
        mem_addr    = DST_BASE + ofs + 8'd1;
        mem_wr_en   = 1'b1;
        mem_wr_data = result[15:8];
      end
      default: ;
    endcase
    // A reset arriving mid-sequence must not commit the write at that edge.
    if (reset) begin
      mem_rd_en = 1'b0;
      mem_wr_en = 1'b0;
    end
  end

  assign done = (state == ST_DONE);
  assign busy = (state != ST_IDLE);

endmodule
